// File: rtl/pipeline_ctrl_if.sv
// Pipeline sequencer bus: per-stage stall requests and the MEM-stage
// exception report flow in, the stall vector, flush/redirect and the
// monitoring counters flow back out to the pipeline.
interface pipeline_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] exc_count;

  // Pipeline stages: raise requests, consume stall/flush/redirect
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype, cp0_epc,
    input  stall, flush, new_pc, stall_timeout, stall_cycles, exc_count
  );

  // Sequencer: arbitrates requests, produces stall/flush/redirect
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype, cp0_epc,
    output stall, flush, new_pc, stall_timeout, stall_cycles, exc_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the five-stage pipeline. Merges stage stall
// requests into a hold vector, converts MEM-stage exceptions into a
// one-cycle flush plus redirect PC, blocks re-entry for one recovery
// cycle, and keeps stall-duration and exception statistics.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  // ERET is the only exception code that returns to EPC instead of the vector
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e      state_q;
  logic [15:0] run_cnt_q;
  logic [15:0] run_cnt_d;
  logic        timeout_q;
  logic        timeout_d;
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic [15:0] exc_count_q;
  logic [15:0] exc_count_d;

  logic [5:0]  stall_req_s;
  logic [5:0]  stall_s;
  logic        exc_s;
  logic [31:0] new_pc_s;
  logic        stall_active_s;

  // Priority-encode stage requests: the deepest stalled stage wins,
  // holding itself and everything upstream of it
  always_comb begin
    stall_req_s = 6'b000000;
    if (bus.stallreq_mem) begin
      stall_req_s = 6'b011111;
    end else if (bus.stallreq_ex) begin
      stall_req_s = 6'b001111;
    end else if (bus.stallreq_id) begin
      stall_req_s = 6'b000111;
    end else if (bus.stallreq_if) begin
      stall_req_s = 6'b000011;
    end else begin
      stall_req_s = 6'b000000;
    end
  end

  // Accept exceptions only in RUN; an accepted exception overrides any stall
  // so the flush and redirect land on the same edge
  always_comb begin
    exc_s    = 1'b0;
    stall_s  = 6'b000000;
    new_pc_s = 32'h0000_0000;
    if (rst) begin
      exc_s    = 1'b0;
      stall_s  = 6'b000000;
      new_pc_s = 32'h0000_0000;
    end else if ((state_q == ST_RUN) && (bus.excepttype != 32'h0000_0000)) begin
      exc_s    = 1'b1;
      stall_s  = 6'b000000;
      new_pc_s = (bus.excepttype == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
    end else begin
      exc_s    = 1'b0;
      stall_s  = stall_req_s;
      new_pc_s = 32'h0000_0000;
    end
  end

  assign stall_active_s = |stall_s;

  // Next values for the stall-run monitor and the statistics counters
  always_comb begin
    run_cnt_d      = 16'h0000;
    stall_cycles_d = stall_cycles_q;
    exc_count_d    = exc_count_q;
    if (!stall_active_s || exc_s) begin
      run_cnt_d = 16'h0000;
    end else if (run_cnt_q == 16'hFFFF) begin
      run_cnt_d = 16'hFFFF;
    end else begin
      run_cnt_d = run_cnt_q + 16'd1;
    end
    // Run counter is zero whenever the pipeline is not stalled, so this also
    // clears the flag on the edge after the stall is released
    timeout_d = (run_cnt_d >= STALL_TIMEOUT);
    if (stall_active_s) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (exc_s) begin
      exc_count_d = exc_count_q + 16'd1;
    end else begin
      exc_count_d = exc_count_q;
    end
  end

  // Recovery FSM plus monitor/counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      run_cnt_q      <= 16'h0000;
      timeout_q      <= 1'b0;
      stall_cycles_q <= 32'h0000_0000;
      exc_count_q    <= 16'h0000;
    end else begin
      case (state_q)
        ST_RUN:     state_q <= exc_s ? ST_RECOVER : ST_RUN;
        ST_RECOVER: state_q <= ST_RUN;
        default:    state_q <= ST_RUN;
      endcase
      run_cnt_q      <= run_cnt_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
      exc_count_q    <= exc_count_d;
    end
  end

  assign bus.stall         = stall_s;
  assign bus.flush         = exc_s;
  assign bus.new_pc        = new_pc_s;
  assign bus.stall_timeout = timeout_q;
  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.exc_count     = exc_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table for stall priority and a
// syscall/recover pass, plus hand sequences for ERET back-to-back, stall
// timeout and reset during recovery.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .STALL_TIMEOUT(16'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;       // {mem, ex, id, if}
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
    bus.stallreq_mem = req[3];
    bus.stallreq_ex  = req[2];
    bus.stallreq_id  = req[1];
    bus.stallreq_if  = req[0];
    bus.excepttype   = exc;
    bus.cp0_epc      = epc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_sc;
    n_checks = 0;
    n_fail   = 0;
    exp_sc   = 0;

    tbl[0]  = '{4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0};
    tbl[1]  = '{4'b0001, 32'h0, 32'h0,    6'b000011, 1'b0, 32'h0};
    tbl[2]  = '{4'b0010, 32'h0, 32'h0,    6'b000111, 1'b0, 32'h0};
    tbl[3]  = '{4'b0100, 32'h0, 32'h0,    6'b001111, 1'b0, 32'h0};
    tbl[4]  = '{4'b1000, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0};
    tbl[5]  = '{4'b0101, 32'h0, 32'h0,    6'b001111, 1'b0, 32'h0};
    tbl[6]  = '{4'b1101, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0};
    tbl[7]  = '{4'b0010, 32'h0, 32'h0,    6'b000111, 1'b0, 32'h0};
    tbl[8]  = '{4'b0011, 32'h0, 32'h0,    6'b000111, 1'b0, 32'h0};
    tbl[9]  = '{4'b1111, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0};
    tbl[10] = '{4'b1000, 32'h8, 32'h5555, 6'b000000, 1'b1, 32'h20};
    tbl[11] = '{4'b0001, 32'h8, 32'h5555, 6'b000011, 1'b0, 32'h0};
    tbl[12] = '{4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0};

    // Reset with every request and an exception pending
    rst = 1'b1;
    drive(4'b1111, 32'h8, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_stall", 32'(bus.stall), 32'h0);
      chk("rst_flush", 32'(bus.flush), 32'h0);
      chk("rst_new_pc", bus.new_pc, 32'h0);
      step();
    end
    chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);
    chk("rst_stall_cycles", bus.stall_cycles, 32'h0);
    chk("rst_exc_count", 32'(bus.exc_count), 32'h0);
    rst = 1'b0;
    drive(4'b0000, 32'h0, 32'h0);
    step();

    // Priority table, including a syscall and the ignored exception in RECOVER
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].req, tbl[i].exc, tbl[i].epc);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), 32'(bus.stall), 32'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d_flush", i), 32'(bus.flush), 32'(tbl[i].exp_flush));
      chk($sformatf("tbl%0d_new_pc", i), bus.new_pc, tbl[i].exp_pc);
      if (tbl[i].exp_stall != 6'b000000) exp_sc++;
      step();
    end
    chk("tbl_exc_count", 32'(bus.exc_count), 32'd1);
    chk("tbl_stall_cycles", bus.stall_cycles, 32'(exp_sc));
    chk("tbl_timeout", 32'(bus.stall_timeout), 32'h0);

    // ERET held three cycles: flush 1,0,1 redirecting to EPC
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 32'h0000_000e, 32'h0000_1234);
      @(negedge clk);
      chk($sformatf("eret%0d_flush", k), 32'(bus.flush), (k == 1) ? 32'h0 : 32'h1);
      chk($sformatf("eret%0d_new_pc", k), bus.new_pc, (k == 1) ? 32'h0 : 32'h1234);
      chk($sformatf("eret%0d_stall", k), 32'(bus.stall), 32'h0);
      step();
    end
    chk("eret_exc_count", 32'(bus.exc_count), 32'd3);
    drive(4'b0000, 32'h0, 32'h0);
    step();
    chk("eret_stall_cycles", bus.stall_cycles, 32'd10);

    // Stall timeout with threshold 4: execute stall held 6 cycles
    for (int i = 1; i <= 6; i++) begin
      drive(4'b0100, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("to%0d_stall", i), 32'(bus.stall), 32'h0000_000f);
      chk($sformatf("to%0d_timeout", i), 32'(bus.stall_timeout), (i >= 5) ? 32'h1 : 32'h0);
      step();
    end
    chk("to_after6", 32'(bus.stall_timeout), 32'h1);
    drive(4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    chk("to_release_hold", 32'(bus.stall_timeout), 32'h1);
    step();
    chk("to_cleared", 32'(bus.stall_timeout), 32'h0);
    chk("to_stall_cycles", bus.stall_cycles, 32'd16);

    // Reset asserted in the recovery cycle, exception right after reset
    drive(4'b0000, 32'h8, 32'h0);
    @(negedge clk);
    chk("mr_flush", 32'(bus.flush), 32'h1);
    step();
    rst = 1'b1;
    drive(4'b0100, 32'h1, 32'h0);
    @(negedge clk);
    chk("mr_rst_flush", 32'(bus.flush), 32'h0);
    chk("mr_rst_stall", 32'(bus.stall), 32'h0);
    step();
    chk("mr_exc_count", 32'(bus.exc_count), 32'h0);
    chk("mr_stall_cycles", bus.stall_cycles, 32'h0);
    rst = 1'b0;
    drive(4'b0000, 32'h1, 32'h0);
    @(negedge clk);
    chk("mr_post_flush", 32'(bus.flush), 32'h1);
    chk("mr_post_new_pc", bus.new_pc, 32'h20);
    step();
    chk("mr_post_exc_count", 32'(bus.exc_count), 32'd1);
    drive(4'b0000, 32'h0, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
